// File: rtl/pipe_hazard_fwd_unit_if.sv
// Pipeline-side bundle for the hazard/forwarding unit: decode tags, operand sources,
// forwarded operands and stall/flush controls.
interface pipe_hazard_fwd_unit_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5
);
    logic              dec_valid;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic              dec_use1;
    logic              dec_use2;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_we;
    logic              dec_ld;
    logic              dec_mem;
    logic              dec_br_taken;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_result;
    logic [DATA_W-1:0] wb_result;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic              pc_stall;
    logic              ifid_stall;
    logic              idex_bubble;
    logic              pipe_freeze;
    logic              ifid_flush;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use1, dec_use2, dec_rd, dec_we,
               dec_ld, dec_mem, dec_br_taken, rf_rd1, rf_rd2, ex_result,
               mem_result, wb_result,
        input  opnd_a, opnd_b, fwd_sel_a, fwd_sel_b, pc_stall, ifid_stall,
               idex_bubble, pipe_freeze, ifid_flush
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use1, dec_use2, dec_rd, dec_we,
               dec_ld, dec_mem, dec_br_taken, rf_rd1, rf_rd2, ex_result,
               mem_result, wb_result,
        output opnd_a, opnd_b, fwd_sel_a, fwd_sel_b, pc_stall, ifid_stall,
               idex_bubble, pipe_freeze, ifid_flush
    );
endinterface

// File: rtl/pipe_hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the IF/DEC/EX/MEM/WB pipeline:
// tracks EX/MEM/WB destination tags, muxes DEC operands, raises stall/bubble/freeze/flush.
module pipe_hazard_fwd_unit #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned MEM_LAT  = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    pipe_hazard_fwd_unit_if.slave bus
);
    localparam int unsigned       CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  FRZ_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [REG_AW-1:0] ZR       = REG_AW'(ZERO_REG);
    localparam logic [1:0]        SEL_RF   = 2'd0;
    localparam logic [1:0]        SEL_EX   = 2'd1;
    localparam logic [1:0]        SEL_MEM  = 2'd2;
    localparam logic [1:0]        SEL_WB   = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
        logic              mem;
    } tag_t;

    tag_t             ex_q, mem_q, wb_q, dec_tag;
    logic [CNT_W-1:0] frz_cnt;
    logic             load_use, freeze, bubble;
    logic [1:0]       sel_a, sel_b;
    logic [DATA_W-1:0] val_a, val_b;

    function automatic logic hit(input tag_t t, input logic [REG_AW-1:0] src, input logic use_src);
        return t.valid & t.we & (t.rd == src) & (src != ZR) & use_src;
    endfunction

    // A load still in EX has no data yet, so it is skipped here and stalls instead.
    function automatic logic [1:0] pick(input logic [REG_AW-1:0] src, input logic use_src);
        if (hit(ex_q, src, use_src) && !ex_q.ld) return SEL_EX;
        else if (hit(mem_q, src, use_src))       return SEL_MEM;
        else if (hit(wb_q, src, use_src))        return SEL_WB;
        else                                     return SEL_RF;
    endfunction

    assign dec_tag = '{valid: 1'b1, rd: bus.dec_rd, we: bus.dec_we,
                       ld: bus.dec_ld, mem: bus.dec_mem};

    // Hazard and control decode
    always_comb begin
        freeze   = (frz_cnt != '0);
        load_use = bus.dec_valid & ex_q.valid & ex_q.ld & (ex_q.rd != ZR) &
                   (hit(ex_q, bus.dec_rs1, bus.dec_use1) | hit(ex_q, bus.dec_rs2, bus.dec_use2));
        bubble   = load_use & ~freeze;

        bus.pc_stall    = load_use | freeze;
        bus.ifid_stall  = load_use | freeze;
        bus.idex_bubble = bubble;
        bus.pipe_freeze = freeze;
        bus.ifid_flush  = bus.dec_br_taken & bus.dec_valid & ~load_use & ~freeze;
    end

    // Operand forwarding muxes
    always_comb begin
        sel_a = pick(bus.dec_rs1, bus.dec_use1);
        sel_b = pick(bus.dec_rs2, bus.dec_use2);
        val_a = bus.rf_rd1;
        val_b = bus.rf_rd2;
        case (sel_a)
            SEL_EX:  val_a = bus.ex_result;
            SEL_MEM: val_a = bus.mem_result;
            SEL_WB:  val_a = bus.wb_result;
            default: val_a = bus.rf_rd1;
        endcase
        case (sel_b)
            SEL_EX:  val_b = bus.ex_result;
            SEL_MEM: val_b = bus.mem_result;
            SEL_WB:  val_b = bus.wb_result;
            default: val_b = bus.rf_rd2;
        endcase
        bus.fwd_sel_a = sel_a;
        bus.fwd_sel_b = sel_b;
        bus.opnd_a    = val_a;
        bus.opnd_b    = val_b;
    end

    // Tag pipeline and memory-latency freeze counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            frz_cnt <= '0;
        end else if (freeze) begin
            frz_cnt <= frz_cnt - CNT_W'(1);
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (bubble || !bus.dec_valid) ? '0 : dec_tag;
            if (ex_q.valid && ex_q.mem) frz_cnt <= FRZ_LOAD;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Directed bench: one unit with single-cycle memory and one with MEM_LAT=3, fed identical stimulus.
module tb_pipe_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    pipe_hazard_fwd_unit_if #(.DATA_W(64), .REG_AW(5)) b1 ();
    pipe_hazard_fwd_unit_if #(.DATA_W(64), .REG_AW(5)) b3 ();

    pipe_hazard_fwd_unit #(.DATA_W(64), .REG_AW(5), .ZERO_REG(31), .MEM_LAT(1))
        u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    pipe_hazard_fwd_unit #(.DATA_W(64), .REG_AW(5), .ZERO_REG(31), .MEM_LAT(3))
        u_lat3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    always #5 clk = ~clk;

    assign b1.dec_valid    = b3.dec_valid;
    assign b1.dec_rs1      = b3.dec_rs1;
    assign b1.dec_rs2      = b3.dec_rs2;
    assign b1.dec_use1     = b3.dec_use1;
    assign b1.dec_use2     = b3.dec_use2;
    assign b1.dec_rd       = b3.dec_rd;
    assign b1.dec_we       = b3.dec_we;
    assign b1.dec_ld       = b3.dec_ld;
    assign b1.dec_mem      = b3.dec_mem;
    assign b1.dec_br_taken = b3.dec_br_taken;
    assign b1.rf_rd1       = b3.rf_rd1;
    assign b1.rf_rd2       = b3.rf_rd2;
    assign b1.ex_result    = b3.ex_result;
    assign b1.mem_result   = b3.mem_result;
    assign b1.wb_result    = b3.wb_result;

    // {pc_stall, ifid_stall, idex_bubble, pipe_freeze, ifid_flush}
    logic [4:0] ctl1, ctl3;
    assign ctl1 = {b1.pc_stall, b1.ifid_stall, b1.idex_bubble, b1.pipe_freeze, b1.ifid_flush};
    assign ctl3 = {b3.pc_stall, b3.ifid_stall, b3.idex_bubble, b3.pipe_freeze, b3.ifid_flush};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2, input logic [4:0] rd,
                           input logic we, input logic ld, input logic mem, input logic br);
        b3.dec_valid = v;  b3.dec_rs1 = rs1; b3.dec_rs2 = rs2;
        b3.dec_use1  = u1; b3.dec_use2 = u2; b3.dec_rd = rd;
        b3.dec_we    = we; b3.dec_ld = ld;   b3.dec_mem = mem; b3.dec_br_taken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        b3.rf_rd1 = 64'hA1; b3.rf_rd2 = 64'hB2;
        b3.ex_result = 64'h5; b3.mem_result = 64'hDEAD; b3.wb_result = 64'h2;
        set_dec(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        #3;
        check("rst_sel_a", 64'(b3.fwd_sel_a), 64'd0);
        check("rst_opnd_a", b3.opnd_a, 64'hA1);
        check("rst_opnd_b", b3.opnd_b, 64'hB2);
        check("rst_ctl", 64'(ctl3), 64'd0);
        tick();
        rst_n = 1'b1;

        // ADD X1 ; ADD X2,X1 -> EX forward
        set_dec(1, 2, 3, 1, 1, 1, 1, 0, 0, 0); tick();
        set_dec(1, 1, 4, 1, 1, 2, 1, 0, 0, 0); #1;
        check("t1_sel_a", 64'(b3.fwd_sel_a), 64'd1);
        check("t1_opnd_a", b3.opnd_a, 64'h5);
        check("t1_sel_b", 64'(b3.fwd_sel_b), 64'd0);
        check("t1_opnd_b", b3.opnd_b, 64'hB2);
        check("t1_ctl", 64'(ctl3), 64'd0);
        tick();

        // LDUR X3 ; ADD X4,X3 -> load-use stall, then MEM forward
        set_dec(1, 6, 0, 1, 0, 3, 1, 1, 1, 0); #1;
        check("t2_pre_ctl", 64'(ctl3), 64'd0);
        tick();
        set_dec(1, 3, 0, 1, 0, 4, 1, 0, 0, 0); #1;
        check("t2_lu_ctl3", 64'(ctl3), 64'b11100);
        check("t2_lu_ctl1", 64'(ctl1), 64'b11100);
        tick();
        check("t2_sel_a3", 64'(b3.fwd_sel_a), 64'd2);
        check("t2_opnd_a3", b3.opnd_a, 64'hDEAD);
        check("t2_frz_ctl3", 64'(ctl3), 64'b11010);
        check("t2_sel_a1", 64'(b1.fwd_sel_a), 64'd2);
        check("t2_ctl1", 64'(ctl1), 64'd0);
        tick();
        check("t2_frz2_ctl3", 64'(ctl3), 64'b11010);
        tick();
        check("t2_end_ctl3", 64'(ctl3), 64'd0);
        check("t2_end_sel_a3", 64'(b3.fwd_sel_a), 64'd2);
        do_reset();

        // Writes to X31 never forward or stall
        set_dec(1, 0, 0, 0, 0, 31, 1, 0, 0, 0); tick();
        set_dec(1, 31, 31, 1, 1, 31, 1, 1, 1, 0); #1;
        check("t3_sel_a", 64'(b3.fwd_sel_a), 64'd0);
        check("t3_sel_b", 64'(b3.fwd_sel_b), 64'd0);
        check("t3_opnd_a", b3.opnd_a, 64'hA1);
        check("t3_ctl", 64'(ctl3), 64'd0);
        tick();
        set_dec(1, 31, 0, 1, 0, 4, 1, 0, 0, 0); #1;
        check("t3_ld_ctl", 64'(ctl3), 64'd0);
        check("t3_ld_sel_a", 64'(b3.fwd_sel_a), 64'd0);
        do_reset();

        // STUR through MEM with MEM_LAT=3: two freeze cycles, tags held
        set_dec(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
        set_dec(1, 7, 8, 1, 1, 0, 0, 0, 1, 0); #1;
        check("t4_sel_a_ex", 64'(b3.fwd_sel_a), 64'd1);
        tick();
        set_dec(1, 7, 0, 1, 0, 9, 1, 0, 0, 0); #1;
        check("t4_sel_a_mem", 64'(b3.fwd_sel_a), 64'd2);
        check("t4_pre_ctl", 64'(ctl3), 64'd0);
        tick();
        set_dec(1, 9, 7, 1, 1, 10, 1, 0, 0, 0); #1;
        check("t4_f1_ctl3", 64'(ctl3), 64'b11010);
        check("t4_f1_sel_a", 64'(b3.fwd_sel_a), 64'd1);
        check("t4_f1_sel_b", 64'(b3.fwd_sel_b), 64'd3);
        check("t4_f1_ctl1", 64'(ctl1), 64'd0);
        tick();
        check("t4_f2_ctl3", 64'(ctl3), 64'b11010);
        check("t4_f2_sel_a", 64'(b3.fwd_sel_a), 64'd1);
        check("t4_f2_sel_b", 64'(b3.fwd_sel_b), 64'd3);
        tick();
        check("t4_f3_ctl3", 64'(ctl3), 64'd0);
        check("t4_f3_sel_b", 64'(b3.fwd_sel_b), 64'd3);
        tick();
        set_dec(1, 9, 10, 1, 1, 11, 1, 0, 0, 0); #1;
        check("t4_run_sel_a", 64'(b3.fwd_sel_a), 64'd2);
        check("t4_run_sel_b", 64'(b3.fwd_sel_b), 64'd1);
        check("t4_run_ctl", 64'(ctl3), 64'd0);
        do_reset();

        // Taken CBZ behind a load-use: flush deferred
        set_dec(1, 6, 0, 1, 0, 3, 1, 1, 1, 0); tick();
        set_dec(1, 3, 0, 1, 0, 0, 0, 0, 0, 1); #1;
        check("t5_lu_ctl3", 64'(ctl3), 64'b11100);
        check("t5_lu_ctl1", 64'(ctl1), 64'b11100);
        tick();
        check("t5_flush_ctl1", 64'(ctl1), 64'b00001);
        check("t5_frz_ctl3", 64'(ctl3), 64'b11010);
        tick();
        check("t5_frz2_ctl3", 64'(ctl3), 64'b11010);
        tick();
        check("t5_flush_ctl3", 64'(ctl3), 64'b00001);
        do_reset();

        // Forward priority on operand B, then reset mid-freeze
        b3.ex_result = 64'h1; b3.mem_result = 64'h33; b3.wb_result = 64'h2;
        set_dec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
        set_dec(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
        set_dec(1, 0, 5, 0, 1, 8, 1, 0, 0, 0); #1;
        check("t6_exmem_sel_b", 64'(b3.fwd_sel_b), 64'd1);
        check("t6_exmem_opnd_b", b3.opnd_b, 64'h1);
        tick();
        set_dec(1, 0, 5, 0, 1, 5, 1, 0, 0, 0); #1;
        check("t6_memwb_sel_b", 64'(b3.fwd_sel_b), 64'd2);
        check("t6_memwb_opnd_b", b3.opnd_b, 64'h33);
        tick();
        set_dec(1, 0, 5, 0, 1, 9, 1, 0, 0, 0); #1;
        check("t6_exwb_sel_b", 64'(b3.fwd_sel_b), 64'd1);
        check("t6_exwb_opnd_b", b3.opnd_b, 64'h1);
        tick();
        set_dec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_dec(1, 0, 9, 0, 1, 0, 0, 0, 0, 0); #1;
        check("t6_frz_ctl3", 64'(ctl3), 64'b11010);
        check("t6_wb_sel_b", 64'(b3.fwd_sel_b), 64'd3);
        check("t6_wb_opnd_b", b3.opnd_b, 64'h2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctl3", 64'(ctl3), 64'd0);
        check("t6_rst_sel_b", 64'(b3.fwd_sel_b), 64'd0);
        check("t6_rst_opnd_b", b3.opnd_b, 64'hB2);
        #2;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
